// File: rtl/pll_seq_ctrl_pkg.sv
// pll_seq_ctrl_pkg: shared types and default timing for the rPLL bring-up sequencer.
// The ADJUST state only exists when PLL_CTRL_PHASE_ADJ_EN is defined.
package pll_seq_ctrl_pkg;

  // Sequencer states. Encodings are fixed so state_dbg is stable across builds.
  typedef enum logic [2:0] {
    RESET_HOLD = 3'd0,
    WAIT_LOCK  = 3'd1,
    STABLE     = 3'd2,
    READY      = 3'd3,
`ifdef PLL_CTRL_PHASE_ADJ_EN
    ADJUST     = 3'd4,
`endif
    FAULT      = 3'd5
  } state_t;

  // Default timing, sized for a 27 MHz reference clock.
  localparam int         DEF_RST_CYCLES    = 16;
  localparam int         DEF_LOCK_TIMEOUT  = 27000;
  localparam int         DEF_LOCK_STABLE   = 256;
  localparam int         DEF_SETTLE_CYCLES = 64;
  localparam int         DEF_MAX_RETRY     = 3;
  localparam logic [3:0] DEF_PSDA_INIT     = 4'b0000;
  localparam logic [3:0] DEF_DUTYDA_INIT   = 4'b1000;

  // Width of the shared cycle counter. It only ever counts up to (limit-1)
  // before the state changes, so clog2 of the largest limit is enough.
  function automatic int cnt_width(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

  // Width of retry_cnt; never below one bit.
  function automatic int retry_width(input int max_retry);
    return (max_retry < 1) ? 1 : $clog2(max_retry + 1);
  endfunction

endpackage

// File: rtl/pll_seq_ctrl_if.sv
// pll_seq_ctrl_if: phase/duty adjust handshake between a requester and the sequencer.
//
// Handshake: adj_req is a level request that the requester holds (with
// adj_psda/adj_dutyda stable) until it sees adj_ack. adj_ack is a one-cycle
// pulse; the sequencer captures adj_psda/adj_dutyda in the same cycle it
// raises adj_ack. The requester must drop adj_req after the ack, otherwise a
// second update starts as soon as the sequencer is back in READY. Requests
// made outside READY are neither acked nor lost: they simply wait.
interface pll_seq_ctrl_if;
  logic       adj_req;
  logic [3:0] adj_psda;
  logic [3:0] adj_dutyda;
  logic       adj_ack;

  modport master (
    output adj_req,
    output adj_psda,
    output adj_dutyda,
    input  adj_ack
  );

  modport slave (
    input  adj_req,
    input  adj_psda,
    input  adj_dutyda,
    output adj_ack
  );
endinterface

// File: rtl/pll_seq_ctrl_sync_ff.sv
// sync_ff: two-flop synchroniser for the asynchronous rPLL LOCK signal.
// Both flops reset to 0 so a stale lock is never seen right after reset.
module sync_ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_seq_ctrl.sv
// pll_seq_ctrl: bring-up sequencer and lock supervisor for the Gowin rPLL.
// Holds the PLL in reset, waits for a stable lock, then raises clk_ready.
// Retries on lock timeout, re-sequences on loss of lock, and goes to a
// sticky fault after too many timeouts. Runs on the PLL reference clock.
// Optional feature macro: PLL_CTRL_PHASE_ADJ_EN enables the ADJUST state and
// the adj_* phase/duty handshake; without it psda/dutyda are constants.
module pll_seq_ctrl
  import pll_seq_ctrl_pkg::*;
#(
  parameter int         RST_CYCLES    = DEF_RST_CYCLES,
  parameter int         LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int         LOCK_STABLE   = DEF_LOCK_STABLE,
  parameter int         SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int         MAX_RETRY     = DEF_MAX_RETRY,
  parameter logic [3:0] PSDA_INIT     = DEF_PSDA_INIT,
  parameter logic [3:0] DUTYDA_INIT   = DEF_DUTYDA_INIT,
  localparam int        RW            = retry_width(MAX_RETRY)
) (
  input  logic          clkin,
  input  logic          reset,
  output logic          pll_reset,
  input  logic          pll_lock,
  output logic          clk_ready,
  output logic          fault,
  output logic [RW-1:0] retry_cnt,
  output logic [3:0]    psda,
  output logic [3:0]    dutyda,
  pll_seq_ctrl_if.slave adj,
  output state_t        state_dbg
);

  localparam int CW = cnt_width(RST_CYCLES, LOCK_TIMEOUT, LOCK_STABLE, SETTLE_CYCLES);

  // Terminal counts: each timed state lasts exactly its limit in cycles,
  // because the counter is zero on the first cycle of every state.
  localparam logic [CW-1:0] RST_LAST     = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE - 1);
  localparam logic [RW-1:0] RETRY_MAX    = RW'(MAX_RETRY);

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [RW-1:0] retry_nxt;
  logic          lock_s;

  // LOCK comes from the PLL analogue domain; synchronise before use.
  sync_ff u_lock_sync (
    .clk (clkin),
    .rst (reset),
    .d   (pll_lock),
    .q   (lock_s)
  );

`ifdef PLL_CTRL_PHASE_ADJ_EN
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);

  logic [3:0] psda_q;
  logic [3:0] dutyda_q;
  logic [3:0] psda_nxt;
  logic [3:0] dutyda_nxt;
  logic       ack_q;
  logic       ack_nxt;
`endif

  // Next-state, retry and adjust decode; defaults hold everything.
  always_comb begin
    state_nxt = state;
    retry_nxt = retry_cnt;
`ifdef PLL_CTRL_PHASE_ADJ_EN
    psda_nxt   = psda_q;
    dutyda_nxt = dutyda_q;
    ack_nxt    = 1'b0;
`endif
    case (state)
      RESET_HOLD: begin
        if (cnt == RST_LAST) state_nxt = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        // A lock arriving on the timeout cycle still counts as a lock.
        if (lock_s) begin
          state_nxt = STABLE;
        end else if (cnt == TIMEOUT_LAST) begin
          if (retry_cnt == RETRY_MAX) begin
            state_nxt = FAULT;
          end else begin
            state_nxt = RESET_HOLD;
            retry_nxt = retry_cnt + 1'b1;
          end
        end
      end
      STABLE: begin
        // A lock glitch restarts the wait without costing a retry.
        if (!lock_s) begin
          state_nxt = WAIT_LOCK;
        end else if (cnt == STABLE_LAST) begin
          state_nxt = READY;
          retry_nxt = '0;
        end
      end
      READY: begin
        // Loss of lock takes priority over a pending adjust request.
        if (!lock_s) begin
          state_nxt = RESET_HOLD;
        end
`ifdef PLL_CTRL_PHASE_ADJ_EN
        else if (adj.adj_req) begin
          state_nxt  = ADJUST;
          psda_nxt   = adj.adj_psda;
          dutyda_nxt = adj.adj_dutyda;
          ack_nxt    = 1'b1;
        end
`endif
      end
`ifdef PLL_CTRL_PHASE_ADJ_EN
      ADJUST: begin
        if (!lock_s) begin
          state_nxt = RESET_HOLD;
        end else if (cnt == SETTLE_LAST) begin
          state_nxt = READY;
        end
      end
`endif
      FAULT: begin
        state_nxt = FAULT;
      end
      default: begin
        state_nxt = RESET_HOLD;
      end
    endcase
  end

  // State, shared counter and registered status outputs. Outputs are
  // decoded from the next state so they line up with the state register.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      state     <= RESET_HOLD;
      cnt       <= '0;
      retry_cnt <= '0;
      pll_reset <= 1'b1;
      clk_ready <= 1'b0;
      fault     <= 1'b0;
    end else begin
      state     <= state_nxt;
      retry_cnt <= retry_nxt;
      // READY and FAULT are untimed, so the counter parks there instead of wrapping.
      if (state_nxt != state) begin
        cnt <= '0;
      end else if ((state != READY) && (state != FAULT)) begin
        cnt <= cnt + 1'b1;
      end
      pll_reset <= (state_nxt == RESET_HOLD) || (state_nxt == FAULT);
      clk_ready <= (state_nxt == READY);
      fault     <= (state_nxt == FAULT);
    end
  end

`ifdef PLL_CTRL_PHASE_ADJ_EN
  // Phase/duty settings and the ack pulse. Settings are kept across
  // re-sequencing; only the asynchronous reset restores the initial values.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      psda_q   <= PSDA_INIT;
      dutyda_q <= DUTYDA_INIT;
      ack_q    <= 1'b0;
    end else begin
      psda_q   <= psda_nxt;
      dutyda_q <= dutyda_nxt;
      ack_q    <= ack_nxt;
    end
  end

  assign psda        = psda_q;
  assign dutyda      = dutyda_q;
  assign adj.adj_ack = ack_q;
`else
  // Without the adjust feature the request side is ignored entirely.
  logic unused_adj;
  assign unused_adj  = ^{adj.adj_req, adj.adj_psda, adj.adj_dutyda};
  assign psda        = PSDA_INIT;
  assign dutyda      = DUTYDA_INIT;
  assign adj.adj_ack = 1'b0;
`endif

  assign state_dbg = state;

endmodule
